// File: rtl/genotype_serial_evaluator.sv
// genotype_serial_evaluator: serial chromosome loader plus exhaustive truth-table fitness sweep
module genotype_serial_evaluator #(
   parameter int IN = 4,
   parameter int OUT = 2,
   parameter int CHROM_W = 49,
   parameter int LOAD_W = 8,
   parameter int SETTLE = 1,
   localparam int FIT_W = $clog2(OUT * (2 ** IN) + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [LOAD_W-1:0]       load_data,
   input  logic                    start,
   input  logic [OUT*(2**IN)-1:0]  target,
   output logic [CHROM_W-1:0]      chrom,
   output logic [IN-1:0]           circ_in,
   input  logic [OUT-1:0]          circ_out,
   output logic                    busy,
   output logic                    done,
   output logic [FIT_W-1:0]        fitness
);
   localparam int NV = 2 ** IN;
   localparam int NWORDS = (CHROM_W + LOAD_W - 1) / LOAD_W;
   localparam int SH_W = NWORDS * LOAD_W;
   localparam int WC_W = $clog2(NWORDS + 1);
   localparam int SC_W = $clog2(SETTLE + 1);
   typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
   state_t state, state_nx;
   logic [CHROM_W-1:0] shadow;
   logic [WC_W-1:0] wcnt;
   logic [IN:0] vcnt;
   logic [SC_W-1:0] scnt;
   logic [FIT_W-1:0] acc, hits;
   logic [OUT-1:0] exp_bits;
   logic full, go, last, take;
   assign full = wcnt == WC_W'(NWORDS);
   assign load_ready = !full;
   assign take = load_valid && load_ready;
   assign go = start && full && state == IDLE;
   assign last = vcnt == (IN + 1)'(NV - 1);
   assign circ_in = vcnt[IN-1:0];
   assign busy = state == APPLY || state == SAMPLE;
   assign done = state == DONE;
   assign exp_bits = target[int'(vcnt[IN-1:0]) * OUT +: OUT];
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = go ? APPLY : IDLE;
         APPLY:   state_nx = scnt == SC_W'(SETTLE - 1) ? SAMPLE : APPLY;
         SAMPLE:  state_nx = last ? DONE : APPLY;
         default: state_nx = IDLE;
      endcase
   end
   always_comb begin
      hits = '0;
      for (int i = 0; i < OUT; i++) hits = hits + FIT_W'(circ_out[i] == exp_bits[i]);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         wcnt <= '0;
         vcnt <= '0;
         scnt <= '0;
         acc <= '0;
         fitness <= '0;
         chrom <= '0;
      end else begin
         state <= state_nx;
         if (go) begin
            chrom <= shadow;
            wcnt <= '0;
            acc <= '0;
            vcnt <= '0;
            scnt <= '0;
         end else if (take) begin
            wcnt <= wcnt + WC_W'(1);
         end
         if (state == APPLY) scnt <= state_nx == SAMPLE ? '0 : scnt + SC_W'(1);
         if (state == SAMPLE) begin
            acc <= acc + hits;
            if (last) fitness <= acc + hits;
            else vcnt <= vcnt + (IN + 1)'(1);
         end
      end
   end
   // shadow needs no reset; bits of the last word past CHROM_W fall off the truncating casts
   always_ff @(posedge clk)
      if (take)
         shadow <= (shadow & ~CHROM_W'(SH_W'({LOAD_W{1'b1}}) << (int'(wcnt) * LOAD_W)))
                 | CHROM_W'(SH_W'(load_data) << (int'(wcnt) * LOAD_W));
endmodule
